// File: rtl/chdr_conv_arbiter_pkg.sv
// Shared constants and types for the CHDR converter arbiter.
// Holds settings-register offsets, port-count limits and the input FSM encoding.
package chdr_conv_arbiter_pkg;

  localparam int unsigned NUM_PORTS_MIN = 2;
  localparam int unsigned NUM_PORTS_MAX = 8;

  localparam int unsigned SR_MASK = 0;
  localparam int unsigned SR_SID  = 1;

  typedef enum logic {
    StIdle,
    StPass
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chdr_conv_order_fifo.sv
// Order FIFO remembering which port owns each packet in flight through the converter.
// Push is ignored when full and pop is ignored when empty.
module chdr_conv_order_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/chdr_conv_arbiter.sv
// Round-robin packet arbiter sharing one CHDR converter between several ports,
// with optional header SID rewrite and in-order routing of converted packets.
module chdr_conv_arbiter
  import chdr_conv_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned BASE        = 0,
  parameter int unsigned ORDER_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic [64*NUM_PORTS-1:0] in_tdata,
  input  logic [NUM_PORTS-1:0]    in_tlast,
  input  logic [NUM_PORTS-1:0]    in_tvalid,
  output logic [NUM_PORTS-1:0]    in_tready,
  output logic [63:0]             c_i_tdata,
  output logic                    c_i_tlast,
  output logic                    c_i_tvalid,
  input  logic                    c_i_tready,
  input  logic [63:0]             c_o_tdata,
  input  logic                    c_o_tlast,
  input  logic                    c_o_tvalid,
  output logic                    c_o_tready,
  output logic [64*NUM_PORTS-1:0] out_tdata,
  output logic [NUM_PORTS-1:0]    out_tlast,
  output logic [NUM_PORTS-1:0]    out_tvalid,
  input  logic [NUM_PORTS-1:0]    out_tready,
  output logic                    busy,
  output logic [15:0]             orphan_cnt
);

  localparam int unsigned IdxW = idx_width(NUM_PORTS);

  arb_state_e           state_q;
  logic [IdxW-1:0]      grant_q, last_grant_q, pick, pick_hi, pick_lo, fifo_head;
  logic                 sof_q, hi_found, pass;
  logic [NUM_PORTS-1:0] mask_q, cand;
  logic                 sid_en_q;
  logic [15:0]          dest_q, orphan_q;
  logic [63:0]          sel_tdata;
  logic                 sel_tvalid, sel_tlast, beat_hs, last_hs;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                 unused_set_data;

  assign unused_set_data = ^set_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q   <= '1;
      sid_en_q <= 1'b0;
      dest_q   <= '0;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE + SR_MASK)) mask_q <= set_data[NUM_PORTS-1:0];
      if (set_addr == 8'(BASE + SR_SID)) begin
        sid_en_q <= set_data[16];
        dest_q   <= set_data[15:0];
      end
    end
  end

  // Lowest candidate above last_grant wins; otherwise wrap to the lowest candidate.
  always_comb begin
    cand     = in_tvalid & mask_q;
    pick_hi  = '0;
    pick_lo  = '0;
    hi_found = 1'b0;
    for (int p = int'(NUM_PORTS) - 1; p >= 0; p--) begin
      if (cand[p]) begin
        pick_lo = IdxW'(p);
        if (IdxW'(p) > last_grant_q) begin
          pick_hi  = IdxW'(p);
          hi_found = 1'b1;
        end
      end
    end
    pick = hi_found ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_tdata  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (IdxW'(p) == grant_q) begin
        sel_tdata  = in_tdata[64*p +: 64];
        sel_tvalid = in_tvalid[p];
        sel_tlast  = in_tlast[p];
      end
    end
  end

  assign pass       = (state_q == StPass);
  assign fifo_push  = (state_q == StIdle) & (|cand) & ~fifo_full;
  assign beat_hs    = pass & sel_tvalid & c_i_tready;
  assign last_hs    = beat_hs & sel_tlast;
  assign c_i_tvalid = pass & sel_tvalid;
  assign c_i_tlast  = pass & sel_tlast;

  always_comb begin
    c_i_tdata = sel_tdata;
    if (sof_q && sid_en_q) c_i_tdata[15:0] = dest_q;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      in_tready[p] = pass & (IdxW'(p) == grant_q) & c_i_tready;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IdxW'(NUM_PORTS - 1);
      sof_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fifo_push) begin
            grant_q <= pick;
            sof_q   <= 1'b1;
            state_q <= StPass;
          end
        end
        StPass: begin
          if (beat_hs) sof_q <= 1'b0;
          if (last_hs) begin
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  chdr_conv_order_fifo #(
    .WIDTH (IdxW),
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (pick),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    out_tvalid = '0;
    c_o_tready = 1'b0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (IdxW'(p) == fifo_head) begin
        out_tvalid[p] = c_o_tvalid & ~fifo_empty;
        c_o_tready    = out_tready[p] & ~fifo_empty;
      end
    end
  end

  assign out_tdata = {NUM_PORTS{c_o_tdata}};
  assign out_tlast = {NUM_PORTS{c_o_tlast}};
  assign fifo_pop  = c_o_tvalid & c_o_tready & c_o_tlast;
  assign busy      = pass | ~fifo_empty;

  // Beats arriving with no owner are stalled, not dropped; count them for debug.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      orphan_q <= '0;
    end else if (c_o_tvalid && fifo_empty && (orphan_q != 16'hFFFF)) begin
      orphan_q <= orphan_q + 16'd1;
    end
  end

  assign orphan_cnt = orphan_q;

endmodule

// File: tb/tb_chdr_conv_arbiter.sv
// Directed bench for chdr_conv_arbiter: arbitration table plus hand-written
// sequences for round-robin, SID rewrite, masking, FIFO-full, orphans and reset.
module tb_chdr_conv_arbiter;

  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            set_stb;
  logic [7:0]      set_addr;
  logic [31:0]     set_data;
  logic [64*NP-1:0] in_tdata;
  logic [NP-1:0]   in_tlast, in_tvalid, in_tready;
  logic [63:0]     c_i_tdata, c_o_tdata;
  logic            c_i_tlast, c_i_tvalid, c_i_tready;
  logic            c_o_tlast, c_o_tvalid, c_o_tready;
  logic [64*NP-1:0] out_tdata;
  logic [NP-1:0]   out_tlast, out_tvalid, out_tready;
  logic            busy;
  logic [15:0]     orphan_cnt;

  chdr_conv_arbiter #(
    .NUM_PORTS   (NP),
    .BASE        (0),
    .ORDER_DEPTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .c_i_tdata  (c_i_tdata),
    .c_i_tlast  (c_i_tlast),
    .c_i_tvalid (c_i_tvalid),
    .c_i_tready (c_i_tready),
    .c_o_tdata  (c_o_tdata),
    .c_o_tlast  (c_o_tlast),
    .c_o_tvalid (c_o_tvalid),
    .c_o_tready (c_o_tready),
    .out_tdata  (out_tdata),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .busy       (busy),
    .orphan_cnt (orphan_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] mask;
    int         exp;
  } vec_t;

  vec_t        vecs [12];
  int          n_cmp, n_bad;
  int          beat [4];
  int          hs, got;
  int          exp_rr [16];
  logic [3:0]  seen;
  logic [63:0] pk [4];
  logic        ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr_set(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [63:0] d);
    in_tdata[p*64 +: 64] = d;
  endtask

  function automatic logic [63:0] pdata(input int p);
    return 64'hA5A5_0000_0000_0000 + 64'(p);
  endfunction

  // Returns converter replies until the order FIFO is empty (FSM must be idle).
  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      c_o_tvalid = 1'b1;
      c_o_tlast  = 1'b1;
      tick();
    end
    c_o_tvalid = 1'b0;
    c_o_tlast  = 1'b0;
    chk("drain_busy", 64'(busy), 64'h0);
  endtask

  // Counts single-beat packets accepted by the converter; stops after n or budget cycles.
  task automatic pump(input int n, input int budget, output int cnt, output logic [3:0] who);
    cnt = 0;
    who = '0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (c_i_tvalid && c_i_tready && c_i_tlast) begin
        cnt++;
        who = who | in_tready;
      end
      tick();
      if (cnt == n) break;
    end
    in_tvalid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{4'b0001, 4'b1111, 0};
    vecs[1]  = '{4'b1111, 4'b1111, 1};
    vecs[2]  = '{4'b1111, 4'b1111, 2};
    vecs[3]  = '{4'b1111, 4'b1111, 3};
    vecs[4]  = '{4'b1011, 4'b1111, 0};
    vecs[5]  = '{4'b1001, 4'b1111, 3};
    vecs[6]  = '{4'b0110, 4'b1011, 1};
    vecs[7]  = '{4'b0111, 4'b1011, 0};
    vecs[8]  = '{4'b0101, 4'b1111, 2};
    vecs[9]  = '{4'b1000, 4'b1111, 3};
    vecs[10] = '{4'b1111, 4'b1110, 1};
    vecs[11] = '{4'b0001, 4'b1111, 0};
    exp_rr = '{-1, 0, 0, 0, -1, 1, 1, 1, -1, 3, 3, 3, -1, 0, 0, 0};
    pk[0] = 64'h0000_0004_DEAD_BEEF;
    pk[1] = 64'h1111_2222_3333_4444;
    pk[2] = 64'h5555_6666_7777_8888;
    pk[3] = 64'h9999_AAAA_BBBB_CCCC;

    reset = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    in_tdata = '0; in_tlast = '0; in_tvalid = '0; c_i_tready = 1'b1;
    c_o_tdata = '0; c_o_tlast = 1'b0; c_o_tvalid = 1'b0; out_tready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_tready", 64'(in_tready), 64'h0);
    chk("rst_c_i_tvalid", 64'(c_i_tvalid), 64'h0);
    chk("rst_c_o_tready", 64'(c_o_tready), 64'h0);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_orphan", 64'(orphan_cnt), 64'h0);
    reset = 1'b1;
    tick();

    // Round-robin: ports 0,1,3 stream 3-beat packets back to back.
    for (int p = 0; p < NP; p++) beat[p] = 0;
    in_tvalid = 4'b1011;
    hs = -1;
    for (int c = 0; c < 16; c++) begin
      if (hs >= 0) begin
        beat[hs] = (beat[hs] == 2) ? 0 : beat[hs] + 1;
      end
      for (int p = 0; p < NP; p++) begin
        in_tlast[p] = (beat[p] == 2);
        set_port(p, 64'h0B00_0000_0000_0000 + 64'(p * 256 + beat[p]));
      end
      #1;
      hs = -1;
      if (c_i_tvalid && c_i_tready) begin
        for (int p = 0; p < NP; p++) if (in_tready[p]) hs = p;
      end
      chk("rr_trace", 64'(hs), 64'(exp_rr[c]));
      tick();
    end
    in_tvalid = '0;
    in_tlast  = '0;
    drain();

    // Single 4-beat packet from port 0, rewrite off.
    in_tvalid = 4'b0001;
    set_port(0, pk[0]);
    tick();
    for (int b = 0; b < 4; b++) begin
      set_port(0, pk[b]);
      in_tlast[0] = (b == 3);
      #1;
      chk("single_c_i_tdata", c_i_tdata, pk[b]);
      if (b == 0) chk("single_in_tready", 64'(in_tready), 64'h1);
      tick();
    end
    in_tvalid = '0;
    in_tlast  = '0;
    #1;
    chk("single_busy_inflight", 64'(busy), 64'h1);
    c_o_tvalid = 1'b1;
    c_o_tlast  = 1'b0;
    c_o_tdata  = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("single_out_tvalid0", 64'(out_tvalid), 64'h1);
    chk("single_c_o_tready", 64'(c_o_tready), 64'h1);
    chk("single_out_bcast", out_tdata[255:192], 64'h0123_4567_89AB_CDEF);
    tick();
    c_o_tlast = 1'b1;
    #1;
    chk("single_out_tvalid1", 64'(out_tvalid), 64'h1);
    tick();
    c_o_tvalid = 1'b0;
    c_o_tlast  = 1'b0;
    #1;
    chk("single_busy_done", 64'(busy), 64'h0);
    tick();

    // Arbitration table: one-beat packets, each answered during its own PASS cycle.
    in_tlast = 4'b1111;
    for (int p = 0; p < NP; p++) set_port(p, pdata(p));
    for (int v = 0; v < 12; v++) begin
      wr_set(8'd0, {28'd0, vecs[v].mask});
      in_tvalid = vecs[v].valid;
      #1;
      chk("tbl_idle_ready", 64'(in_tready), 64'h0);
      tick();
      c_o_tvalid = 1'b1;
      c_o_tlast  = 1'b1;
      #1;
      chk("tbl_c_i_tvalid", 64'(c_i_tvalid), 64'h1);
      chk("tbl_in_tready", 64'(in_tready), 64'(4'b0001 << vecs[v].exp));
      chk("tbl_c_i_tdata", c_i_tdata, pdata(vecs[v].exp));
      chk("tbl_out_tvalid", 64'(out_tvalid), 64'(4'b0001 << vecs[v].exp));
      chk("tbl_c_o_tready", 64'(c_o_tready), 64'h1);
      tick();
      in_tvalid  = '0;
      c_o_tvalid = 1'b0;
      c_o_tlast  = 1'b0;
    end
    in_tlast = '0;
    wr_set(8'd0, 32'h0000_000F);

    // SID rewrite on port 2.
    wr_set(8'd1, 32'h0001_FEED);
    in_tvalid = 4'b0100;
    set_port(2, 64'h0123_4567_DEAD_BEEF);
    tick();
    #1;
    chk("sid_header", c_i_tdata, 64'h0123_4567_DEAD_FEED);
    tick();
    set_port(2, 64'hCAFE_0000_1111_2222);
    in_tlast[2] = 1'b1;
    #1;
    chk("sid_payload", c_i_tdata, 64'hCAFE_0000_1111_2222);
    tick();
    in_tvalid = '0;
    in_tlast  = '0;
    drain();
    wr_set(8'd1, 32'h0);

    // Return-path backpressure with FIFO head 2.
    in_tvalid = 4'b0100;
    in_tlast  = 4'b0100;
    tick();
    tick();
    in_tvalid  = '0;
    in_tlast   = '0;
    out_tready = 4'b1011;
    c_o_tvalid = 1'b1;
    c_o_tlast  = 1'b1;
    #1;
    chk("bp_c_o_tready", 64'(c_o_tready), 64'h0);
    chk("bp_out_tvalid", 64'(out_tvalid), 64'h4);
    tick();
    out_tready = '1;
    #1;
    chk("bp_release", 64'(c_o_tready), 64'h1);
    tick();
    c_o_tvalid = 1'b0;
    c_o_tlast  = 1'b0;
    #1;
    chk("bp_busy", 64'(busy), 64'h0);
    tick();

    // Mask port 1 out while its packet is in flight.
    in_tvalid = 4'b0010;
    in_tlast  = '0;
    tick();
    ok = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_port(1, 64'h1111_0000_0000_0000 + 64'(b));
      in_tlast[1] = (b == 3);
      if (b == 0) begin
        set_stb  = 1'b1;
        set_addr = 8'd0;
        set_data = 32'h0000_000D;
      end else begin
        set_stb = 1'b0;
      end
      #1;
      if (!(c_i_tvalid && in_tready == 4'b0010 &&
            c_i_tdata == 64'h1111_0000_0000_0000 + 64'(b))) ok = 1'b0;
      tick();
    end
    set_stb = 1'b0;
    chk("mask_midpkt_beats", 64'(ok), 64'h1);
    in_tvalid = 4'b1111;
    in_tlast  = 4'b1111;
    pump(4, 20, got, seen);
    chk("mask_after_count", 64'(got), 64'h4);
    chk("mask_port1_never", 64'(seen[1]), 64'h0);
    in_tlast = '0;
    drain();
    wr_set(8'd0, 32'h0000_000F);

    // Order FIFO full: converter never answers, so only 8 packets get in.
    in_tvalid = 4'b1111;
    in_tlast  = 4'b1111;
    pump(9, 30, got, seen);
    chk("full_grants", 64'(got), 64'h8);
    chk("full_busy", 64'(busy), 64'h1);
    in_tvalid  = 4'b1111;
    c_o_tvalid = 1'b1;
    c_o_tlast  = 1'b1;
    tick();
    c_o_tvalid = 1'b0;
    c_o_tlast  = 1'b0;
    pump(1, 10, got, seen);
    chk("full_after_pop", 64'(got), 64'h1);
    in_tlast = '0;
    tick();
    drain();

    // Orphan beats with an empty FIFO.
    c_o_tvalid = 1'b1;
    c_o_tlast  = 1'b1;
    #1;
    chk("orphan_stall", 64'(c_o_tready), 64'h0);
    tick();
    tick();
    tick();
    c_o_tvalid = 1'b0;
    c_o_tlast  = 1'b0;
    #1;
    chk("orphan_cnt", 64'(orphan_cnt), 64'h3);
    tick();

    // Asynchronous reset in the middle of a packet.
    in_tvalid = 4'b0001;
    in_tlast  = '0;
    set_port(0, pk[1]);
    tick();
    tick();
    c_o_tvalid = 1'b1;
    #1;
    chk("prerst_out_tvalid", 64'(out_tvalid), 64'h1);
    chk("prerst_in_tready", 64'(in_tready), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_in_tready", 64'(in_tready), 64'h0);
    chk("arst_c_i_tvalid", 64'(c_i_tvalid), 64'h0);
    chk("arst_c_o_tready", 64'(c_o_tready), 64'h0);
    chk("arst_out_tvalid", 64'(out_tvalid), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    in_tvalid  = '0;
    c_o_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b1;
    c_o_tvalid = 1'b1;
    #1;
    chk("postrst_c_o_tready", 64'(c_o_tready), 64'h0);
    chk("postrst_out_tvalid", 64'(out_tvalid), 64'h0);
    chk("postrst_busy", 64'(busy), 64'h0);
    chk("postrst_orphan", 64'(orphan_cnt), 64'h0);
    c_o_tvalid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
